ifetch_queue: RTL and testbench

//  Front end that feeds the decode stage: fetches 32-bit instructions from the memory controller,

---
 rtl/ifetch_queue.sv | 133 +++++++++++++
 tb/tb_ifetch_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: fetches one word at a time and predicts the next PC statically.
// Each fetched word is buffered with its pc and predicted pc in a FIFO that feeds decode.
module ifetch_queue #(
   parameter int IQ_DEPTH = 8,
   parameter int IQ_AW    = 3
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_valid,
   input  logic [31:0] mem_data,
   output logic        decode_flag,
   output logic [31:0] ins,
   output logic [31:0] ins_pc,
   output logic [31:0] ins_pred_pc,
   input  logic        decode_ok,
   input  logic        flush_in,
   input  logic [31:0] flush_pc
);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   localparam logic [IQ_AW:0]   CNT_FULL = IQ_DEPTH[IQ_AW:0];
   localparam logic [IQ_AW:0]   CNT_ONE  = 1;
   localparam logic [IQ_AW-1:0] PTR_ONE  = 1;

   state_t            state;
   logic [31:0]       fetch_pc;
   logic [31:0]       q_ins  [IQ_DEPTH];
   logic [31:0]       q_pc   [IQ_DEPTH];
   logic [31:0]       q_pred [IQ_DEPTH];
   logic [IQ_AW-1:0]  head;
   logic [IQ_AW-1:0]  tail;
   logic [IQ_AW:0]    count;
   logic              pop;
   logic              push;
   logic              issue;
   logic [6:0]        opcode;
   logic [31:0]       imm_j;
   logic [31:0]       imm_b;
   logic [31:0]       pred_pc;

   // Static prediction: JAL always taken, branches taken only when backward.
   always_comb begin
      opcode  = mem_data[6:0];
      imm_j   = {{11{mem_data[31]}}, mem_data[31], mem_data[19:12], mem_data[20],
                 mem_data[30:21], 1'b0};
      imm_b   = {{19{mem_data[31]}}, mem_data[31], mem_data[7], mem_data[30:25],
                 mem_data[11:8], 1'b0};
      pred_pc = fetch_pc + 32'd4;
      if (opcode == 7'b1101111)
         pred_pc = fetch_pc + imm_j;
      else if (opcode == 7'b1100011 && mem_data[31])
         pred_pc = fetch_pc + imm_b;
   end

   assign decode_flag = (count != '0);
   assign ins         = decode_flag ? q_ins[head]  : '0;
   assign ins_pc      = decode_flag ? q_pc[head]   : '0;
   assign ins_pred_pc = decode_flag ? q_pred[head] : '0;

   // A pop in the same cycle frees a slot, so a full queue can still issue when draining.
   assign pop   = decode_flag && decode_ok && !flush_in;
   assign push  = (state == WAIT) && mem_valid && !flush_in;
   assign issue = (state == IDLE) && !flush_in && ((count != CNT_FULL) || pop);

   always_ff @(posedge clk_in) begin
      if (rdy_in && rst_in && push) begin
         q_ins[tail]  <= mem_data;
         q_pc[tail]   <= fetch_pc;
         q_pred[tail] <= pred_pc;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state    <= IDLE;
         fetch_pc <= '0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
      end else if (rdy_in) begin
         if (flush_in) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fetch_pc <= flush_pc;
         end else begin
            if (push)
               tail <= tail + PTR_ONE;
            if (pop)
               head <= head + PTR_ONE;
            if (push && !pop)
               count <= count + CNT_ONE;
            else if (pop && !push)
               count <= count - CNT_ONE;
         end

         // The memory controller cannot cancel a request, so a flushed fetch drains in DROP.
         case (state)
            IDLE: begin
               if (issue) begin
                  mem_req  <= 1'b1;
                  mem_addr <= fetch_pc;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (mem_valid) begin
                  mem_req <= 1'b0;
                  state   <= IDLE;
                  if (!flush_in)
                     fetch_pc <= pred_pc;
               end else if (flush_in) begin
                  state <= DROP;
               end
            end
            DROP: begin
               if (mem_valid) begin
                  mem_req <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized scoreboard bench for ifetch_queue: a driver models the memory controller and
// predicts queue entries; a monitor pops expected entries whenever decode consumes the head.
module tb_ifetch_queue;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
      logic [31:0] pred;
   } entry_t;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        rdy_in = 1'b0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_data = '0;
   logic        decode_flag;
   logic [31:0] ins;
   logic [31:0] ins_pc;
   logic [31:0] ins_pred_pc;
   logic        decode_ok = 1'b0;
   logic        flush_in = 1'b0;
   logic [31:0] flush_pc = '0;

   entry_t      sbq[$];
   entry_t      pending;
   int          checks = 0;
   int          failures = 0;
   int          accepted = 0;
   bit          running = 0;
   bit          outstanding = 0;
   bit          stale = 0;
   bit          just_responded = 0;
   bit          push_pending = 0;
   bit          hold_decode = 0;
   bit          did_reset = 0;
   bit          check_reset = 0;
   logic [31:0] exp_pc = '0;
   logic [31:0] req_addr = '0;

   ifetch_queue #(.IQ_DEPTH(8), .IQ_AW(3)) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .rdy_in      (rdy_in),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_valid   (mem_valid),
      .mem_data    (mem_data),
      .decode_flag (decode_flag),
      .ins         (ins),
      .ins_pc      (ins_pc),
      .ins_pred_pc (ins_pred_pc),
      .decode_ok   (decode_ok),
      .flush_in    (flush_in),
      .flush_pc    (flush_pc)
   );

   always #5 clk_in = ~clk_in;

   // Reference next-pc rule evaluated as signed integer offsets.
   function automatic logic [31:0] refPred(input logic [31:0] w, input logic [31:0] pc);
      int off;
      off = 4;
      if (w[6:0] == 7'b1101111) begin
         off = (w[31] ? -(1 << 20) : 0) + (int'(w[19:12]) << 12) + (int'(w[20]) << 11)
               + (int'(w[30:21]) << 1);
      end else if (w[6:0] == 7'b1100011) begin
         off = (w[31] ? -4096 : 0) + (int'(w[7]) << 11) + (int'(w[30:25]) << 5)
               + (int'(w[11:8]) << 1);
         if (off >= 0)
            off = 4;
      end
      return pc + 32'(off);
   endfunction

   function automatic logic [31:0] pickWord();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0013;
         1:       return 32'h0080_006F;
         2:       return 32'hFE00_0EE3;
         3:       return 32'h0000_0463;
         4:       return 32'h0000_0067;
         default: return $urandom();
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic checkResetOutputs();
      checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
      checkOutput("rst_mem_addr", mem_addr, 32'd0);
      checkOutput("rst_decode_flag", 32'(decode_flag), 32'd0);
      checkOutput("rst_ins", ins, 32'd0);
      checkOutput("rst_ins_pc", ins_pc, 32'd0);
      checkOutput("rst_ins_pred_pc", ins_pred_pc, 32'd0);
   endtask

   // Drives one cycle of inputs and updates the model for the coming edge.
   task automatic applyStimulus(input int cyc);
      bit resp;
      logic [31:0] pred;
      push_pending   = 0;
      just_responded = 0;
      rst_in         = 1'b1;
      if (cyc < 30) begin
         rdy_in   = 1'b1;
         flush_in = 1'b0;
         resp     = outstanding;
         mem_data = 32'h0000_0013;
      end else begin
         rdy_in   = ($urandom_range(0, 99) >= 8);
         flush_in = !hold_decode && ($urandom_range(0, 99) < 3);
         resp     = outstanding && ($urandom_range(0, 99) < 60);
         mem_data = pickWord();
      end
      decode_ok = hold_decode ? 1'b0 : ($urandom_range(0, 99) < 55);
      flush_pc  = ($urandom_range(0, 3) == 0) ? 32'h100 : (32'($urandom_range(0, 1023)) << 2);
      mem_valid = resp;
      if (rdy_in) begin
         if (resp) begin
            outstanding    = 0;
            just_responded = 1;
            if (!stale && !flush_in) begin
               pred         = refPred(mem_data, req_addr);
               pending      = '{mem_data, req_addr, pred};
               push_pending = 1;
               exp_pc       = pred;
               accepted++;
            end
         end else if (flush_in && outstanding) begin
            stale = 1;
         end
         if (flush_in)
            exp_pc = flush_pc;
      end
   endtask

   // Monitor: compares the head whenever decode consumes it.
   initial begin
      entry_t e;
      forever begin
         @(negedge clk_in);
         #2;
         if (!running)
            continue;
         if (!rst_in) begin
            sbq.delete();
            continue;
         end
         checkOutput("decode_flag", 32'(decode_flag), 32'(sbq.size() != 0));
         if (!rdy_in)
            continue;
         if (flush_in) begin
            sbq.delete();
         end else if (decode_flag && decode_ok) begin
            if (sbq.size() == 0) begin
               checkOutput("pop_when_empty", 32'(decode_flag), 32'd0);
            end else begin
               e = sbq.pop_front();
               checkOutput("ins", ins, e.word);
               checkOutput("ins_pc", ins_pc, e.pc);
               checkOutput("ins_pred_pc", ins_pred_pc, e.pred);
            end
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      checkResetOutputs();
      rst_in  = 1'b1;
      rdy_in  = 1'b1;
      running = 1;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk_in);
         hold_decode = (cyc >= 400 && cyc < 520);
         if (check_reset) begin
            checkResetOutputs();
            check_reset = 0;
         end else if (just_responded) begin
            checkOutput("req_clear", 32'(mem_req), 32'd0);
         end else if (!outstanding && mem_req) begin
            checkOutput("mem_addr", mem_addr, exp_pc);
            checkOutput("issue_room", 32'(sbq.size() < 8), 32'd1);
            outstanding = 1;
            stale       = 0;
            req_addr    = exp_pc;
         end

         if (cyc >= 2000 && !did_reset && outstanding) begin
            rst_in         = 1'b0;
            rdy_in         = 1'($urandom_range(0, 1));
            decode_ok      = 1'b1;
            flush_in       = 1'b0;
            mem_valid      = 1'b0;
            did_reset      = 1;
            check_reset    = 1;
            outstanding    = 0;
            stale          = 0;
            just_responded = 0;
            push_pending   = 0;
            exp_pc         = '0;
         end else begin
            applyStimulus(cyc);
         end

         @(posedge clk_in);
         #1;
         if (push_pending)
            sbq.push_back(pending);
      end

      checkOutput("made_progress", 32'(accepted > 200), 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
